// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Shares one memory request/response port between the instruction fetch unit
// (IFU) and the load/store unit (LSU). Only one transaction is in flight at a
// time. When both units request together, the round-robin priority decides
// which one is granted.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   ifu_req_*  / ifu_resp_*       IFU read-only request and response channels
//   lsu_req_*  / lsu_resp_*       LSU load/store request and response channels
//   mem_req_*, mem_addr/wen/
//   mem_wdata/mem_wstrb           request to memory, driven only from registers
//   mem_resp_*, mem_rdata         memory response, passed through to the owner
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                      ifu_resp_valid,
    input  logic                      ifu_resp_ready,
    output logic [DATA_WIDTH-1:0]     ifu_resp_rdata,

    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                      lsu_req_wen,
    input  logic [DATA_WIDTH-1:0]     lsu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   lsu_req_wstrb,
    output logic                      lsu_resp_valid,
    input  logic                      lsu_resp_ready,
    output logic [DATA_WIDTH-1:0]     lsu_resp_rdata,

    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_wen,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic                      mem_resp_valid,
    output logic                      mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Encoding shared by owner and prio.
    localparam logic SEL_IFU = 1'b0;
    localparam logic SEL_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic                      owner_reg, owner_next;
    logic                      prio_reg, prio_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                      wen_reg, wen_next;
    logic [DATA_WIDTH-1:0]     wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0]     wstrb_reg, wstrb_next;

    logic grant_ifu;
    logic grant_lsu;

    // A lone requester always wins; prio only breaks a tie.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (prio_reg == SEL_LSU));
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || (prio_reg == SEL_IFU));

    // Memory request fields come straight from the latched registers so they
    // cannot change while the memory is stalling the request.
    assign mem_addr  = addr_reg;
    assign mem_wen   = wen_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            owner_reg <= SEL_IFU;
            prio_reg  <= SEL_LSU;
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            prio_reg  <= prio_next;
            addr_reg  <= addr_next;
            wen_reg   <= wen_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        prio_next      = prio_reg;
        addr_next      = addr_reg;
        wen_next       = wen_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;

        case (state_reg)
            IDLE: begin
                // Gating with rst keeps the readies low while reset is held,
                // even though the state already reads IDLE.
                ifu_req_ready = grant_ifu && rst;
                lsu_req_ready = grant_lsu && rst;
                if (lsu_req_ready) begin
                    owner_next = SEL_LSU;
                    addr_next  = lsu_req_addr;
                    wen_next   = lsu_req_wen;
                    wdata_next = lsu_req_wdata;
                    wstrb_next = lsu_req_wstrb;
                    state_next = REQ;
                end else if (ifu_req_ready) begin
                    owner_next = SEL_IFU;
                    addr_next  = ifu_req_addr;
                    wen_next   = 1'b0;
                    wdata_next = '0;
                    wstrb_next = '1;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // Response is a pure pass-through to whoever owns the
                // transaction; the other side sees nothing.
                if (owner_reg == SEL_LSU) begin
                    mem_resp_ready = lsu_resp_ready;
                    lsu_resp_valid = mem_resp_valid;
                    lsu_resp_rdata = mem_rdata;
                end else begin
                    mem_resp_ready = ifu_resp_ready;
                    ifu_resp_valid = mem_resp_valid;
                    ifu_resp_rdata = mem_rdata;
                end
                if (mem_resp_valid && mem_resp_ready) begin
                    state_next = IDLE;
                    prio_next  = ~owner_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: scenario tasks drive both requesters and a
// hand-stepped memory; expected memory requests and responses are queued when
// a request is driven and popped by a monitor when the handshake happens.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_resp_valid, ifu_resp_ready;
    logic [DW-1:0] ifu_resp_rdata;
    logic          lsu_req_valid, lsu_req_ready;
    logic [AW-1:0] lsu_req_addr;
    logic          lsu_req_wen;
    logic [DW-1:0] lsu_req_wdata;
    logic [SW-1:0] lsu_req_wstrb;
    logic          lsu_resp_valid, lsu_resp_ready;
    logic [DW-1:0] lsu_resp_rdata;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_resp_valid, mem_resp_ready;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } mem_exp_t;

    typedef struct {
        logic          lsu;
        logic          is_store;
        logic [DW-1:0] rdata;
    } resp_exp_t;

    mem_exp_t  exp_mem_q[$];
    resp_exp_t exp_resp_q[$];
    mem_exp_t  mon_me;
    resp_exp_t mon_re;

    mem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic push_txn(input logic lsu, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                            input logic [DW-1:0] rd);
        mem_exp_t  me;
        resp_exp_t re;
        me.addr = a; me.wen = w; me.wdata = wd; me.wstrb = ws;
        re.lsu = lsu; re.is_store = w; re.rdata = rd;
        exp_mem_q.push_back(me);
        exp_resp_q.push_back(re);
    endtask

    // Scoreboard monitor: sampled on the falling edge, half a cycle away from
    // the edge that completes each handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req_valid && mem_req_ready) begin
                checks++;
                if (exp_mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_req_unexpected: got addr=%h, required no request", mem_addr);
                end else begin
                    mon_me = exp_mem_q.pop_front();
                    if ({mem_addr, mem_wen, mem_wdata, mem_wstrb} !==
                        {mon_me.addr, mon_me.wen, mon_me.wdata, mon_me.wstrb}) begin
                        errors++;
                        $display("FAIL mem_req: got %h/%b/%h/%h, required %h/%b/%h/%h",
                                 mem_addr, mem_wen, mem_wdata, mem_wstrb,
                                 mon_me.addr, mon_me.wen, mon_me.wdata, mon_me.wstrb);
                    end else begin
                        $display("mem req addr=%h wen=%b wdata=%h wstrb=%h",
                                 mem_addr, mem_wen, mem_wdata, mem_wstrb);
                    end
                end
            end
            if (ifu_resp_valid && ifu_resp_ready) begin
                checks++;
                if (exp_resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ifu_resp_unexpected: got rdata=%h, required none", ifu_resp_rdata);
                end else begin
                    mon_re = exp_resp_q.pop_front();
                    if (mon_re.lsu !== 1'b0 || ifu_resp_rdata !== mon_re.rdata) begin
                        errors++;
                        $display("FAIL ifu_resp: got IFU rdata=%h, required lsu=%b rdata=%h",
                                 ifu_resp_rdata, mon_re.lsu, mon_re.rdata);
                    end else begin
                        $display("ifu resp rdata=%h", ifu_resp_rdata);
                    end
                end
            end
            if (lsu_resp_valid && lsu_resp_ready) begin
                checks++;
                if (exp_resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lsu_resp_unexpected: got rdata=%h, required none", lsu_resp_rdata);
                end else begin
                    mon_re = exp_resp_q.pop_front();
                    if (mon_re.lsu !== 1'b1 ||
                        (!mon_re.is_store && lsu_resp_rdata !== mon_re.rdata)) begin
                        errors++;
                        $display("FAIL lsu_resp: got LSU rdata=%h, required lsu=%b rdata=%h",
                                 lsu_resp_rdata, mon_re.lsu, mon_re.rdata);
                    end else begin
                        $display("lsu resp rdata=%h store=%b", lsu_resp_rdata, mon_re.is_store);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h100;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h200;
        mem_resp_valid = 1'b1; ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        mem_req_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
             ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b, required 000000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
                      ifu_resp_valid, lsu_resp_valid});
        end
        checks++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%b/%h/%h, required all zero",
                     mem_addr, mem_wen, mem_wdata, mem_wstrb);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_prio_lsu: got lsu/ifu ready=%b, required 10",
                     {lsu_req_ready, ifu_req_ready});
        end
        checks++;
        if (mem_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_stray_resp: got mem_resp_ready=%b, required 0", mem_resp_ready);
        end
        // Withdraw before the edge: no handshake, nothing should happen.
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
        tick();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_no_effect: got mem_req_valid=%b, required 0", mem_req_valid);
        end
        $display("reset test done");
    endtask

    task automatic test_lsu_store();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1004; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'h3;
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL store_grant: got lsu/ifu ready=%b, required 10",
                     {lsu_req_ready, ifu_req_ready});
        end
        push_txn(1'b1, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h0);
        tick();
        // After the handshake the LSU is free to change its payload.
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 ||
                {mem_addr, mem_wen, mem_wdata, mem_wstrb} !== {32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'h3}) begin
                errors++;
                $display("FAIL store_stable[%0d]: got v=%b %h/%b/%h/%h, required v=1 80001004/1/deadbeef/3",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb);
            end
            tick();
        end
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0000; lsu_resp_ready = 1'b1; ifu_resp_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, lsu_resp_valid, ifu_resp_valid, mem_resp_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL store_resp: got reqv/lsuv/ifuv/mrdy=%b, required 0101",
                     {mem_req_valid, lsu_resp_valid, ifu_resp_valid, mem_resp_ready});
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (lsu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_resp_pulse: got lsu_resp_valid=%b, required 0", lsu_resp_valid);
        end
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ifu_grant: got ifu/lsu ready=%b, required 10", {ifu_req_ready, lsu_req_ready});
        end
        push_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'hF, 32'h0000_0413);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_wen, mem_wstrb} !== {1'b1, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL ifu_mem_req: got v/wen/wstrb=%b/%b/%h, required 1/0/f",
                     mem_req_valid, mem_wen, mem_wstrb);
        end
        tick();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_req_one_cycle: got mem_req_valid=%b, required 0", mem_req_valid);
        end
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10 || ifu_resp_rdata !== 32'h0000_0413 ||
            lsu_resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ifu_resp_route: got ifuv/lsuv=%b ifu=%h lsu=%h, required 10 00000413 00000000",
                     {ifu_resp_valid, lsu_resp_valid}, ifu_resp_rdata, lsu_resp_rdata);
        end
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] ia, la, a;
        logic          exp_lsu;
        ia = 32'h0000_1000; la = 32'h0000_2000;
        ifu_req_valid = 1'b1; ifu_req_addr = ia;
        lsu_req_valid = 1'b1; lsu_req_addr = la; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h1111_2222; lsu_req_wstrb = 4'hC;
        ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1; mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_lsu = (k % 2 == 0);
            #1;
            checks++;
            if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got lsu/ifu ready=%b, required %b",
                         k, {lsu_req_ready, ifu_req_ready}, {exp_lsu, !exp_lsu});
            end
            a = exp_lsu ? la : ia;
            if (exp_lsu) push_txn(1'b1, a, 1'b0, 32'h1111_2222, 4'hC, mem_fn(a));
            else         push_txn(1'b0, a, 1'b0, 32'h0, 4'hF, mem_fn(a));
            tick();
            if (exp_lsu) begin la = la + 4; lsu_req_addr = la; end
            else         begin ia = ia + 4; ifu_req_addr = ia; end
            tick();
            mem_resp_valid = 1'b1; mem_rdata = mem_fn(a);
            tick();
            mem_resp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_4000;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_3000; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'hF;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant: got lsu/ifu ready=%b, required 10", {lsu_req_ready, ifu_req_ready});
        end
        push_txn(1'b1, 32'h0000_3000, 1'b0, 32'h0, 4'hF, 32'h1234_5678);
        tick();
        lsu_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; lsu_resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({mem_resp_ready, lsu_resp_valid, ifu_req_ready, mem_req_valid} !== 4'b0100) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got mrdy/lsuv/ifurdy/reqv=%b, required 0100",
                         i, {mem_resp_ready, lsu_resp_valid, ifu_req_ready, mem_req_valid});
            end
            tick();
        end
        lsu_resp_ready = 1'b1;
        #1;
        checks++;
        if (mem_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got mem_resp_ready=%b, required 1", mem_resp_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_ifu: got ifu_req_ready=%b, required 1", ifu_req_ready);
        end
    endtask

    task automatic test_reset_in_req();
        // IFU is waiting and holds priority; let it into REQ, then reset.
        mem_req_ready = 1'b0;
        tick();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_5000; lsu_req_wen = 1'b0; lsu_req_wstrb = 4'hF;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_req: got mem_req_valid=%b, required 1", mem_req_valid);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid} !== 4'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rst_async: got reqv/ifurdy/lsurdy/ifuv=%b addr=%h, required 0000 00000000",
                     {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid}, mem_addr);
        end
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_restart_prio: got lsu/ifu ready=%b, required 10", {lsu_req_ready, ifu_req_ready});
        end
        push_txn(1'b1, 32'h0000_5000, 1'b0, lsu_req_wdata, 4'hF, mem_fn(32'h0000_5000));
        mem_req_ready = 1'b1;
        tick();
        lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_rdata = mem_fn(32'h0000_5000); lsu_resp_ready = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        checks++;
        if (exp_mem_q.size() != 0 || exp_resp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d mem / %0d resp pending, required 0/0",
                     exp_mem_q.size(), exp_resp_q.size());
        end
    endtask

    initial begin
        ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0;
        lsu_req_wdata = '0; lsu_req_wstrb = '0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        rst = 1'b0;
        test_reset();
        test_lsu_store();
        test_ifu_read();
        test_round_robin();
        test_backpressure();
        test_reset_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
